// File: rtl/vga_index_mem_arbiter_if.sv
// Bus bundle between the pixel-index RAM arbiter and its environment
// (processor write port, VGA refresh reader, clear control, index RAM).
interface vga_index_mem_arbiter_if #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              iWR_EN;
  logic [ADDR_W-1:0] iWR_ADDR;
  logic [DATA_W-1:0] iWR_DATA;
  logic              oWR_FULL;
  logic [LVL_W-1:0]  oFIFO_LEVEL;
  logic              oOVF;
  logic              iRD_REQ;
  logic [ADDR_W-1:0] iRD_ADDR;
  logic [DATA_W-1:0] oRD_DATA;
  logic              oRD_VALID;
  logic              iCLR_START;
  logic [DATA_W-1:0] iCLR_DATA;
  logic              oCLR_BUSY;
  logic [ADDR_W-1:0] oMEM_ADDR;
  logic [DATA_W-1:0] oMEM_WDATA;
  logic              oMEM_WE;
  logic [DATA_W-1:0] iMEM_Q;

  modport master (
    output iWR_EN, iWR_ADDR, iWR_DATA,
    output iRD_REQ, iRD_ADDR,
    output iCLR_START, iCLR_DATA,
    output iMEM_Q,
    input  oWR_FULL, oFIFO_LEVEL, oOVF,
    input  oRD_DATA, oRD_VALID, oCLR_BUSY,
    input  oMEM_ADDR, oMEM_WDATA, oMEM_WE
  );

  modport slave (
    input  iWR_EN, iWR_ADDR, iWR_DATA,
    input  iRD_REQ, iRD_ADDR,
    input  iCLR_START, iCLR_DATA,
    input  iMEM_Q,
    output oWR_FULL, oFIFO_LEVEL, oOVF,
    output oRD_DATA, oRD_VALID, oCLR_BUSY,
    output oMEM_ADDR, oMEM_WDATA, oMEM_WE
  );
endinterface

// File: rtl/vga_index_mem_arbiter.sv
// Single-port VGA index RAM arbiter: refresh reads > clear engine >
// buffered processor writes, one registered RAM access per cycle.
module vga_index_mem_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int MEM_DEPTH  = 307200
) (
  input logic                   iCLK,
  input logic                   iRST,
  vga_index_mem_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic {C_IDLE, C_RUN} clr_state_e;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0] clr_data_q, clr_data_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [LVL_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              rd_p_q, rd_p_d;
  logic              rd_vld_q, rd_vld_d;

  logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              full, empty, push;
  logic              gnt_rd, gnt_clr, gnt_fifo;

  assign full      = (cnt_q == FULL_LVL);
  assign empty     = (cnt_q == '0);
  assign push      = bus.iWR_EN & ~full;
  assign gnt_rd    = bus.iRD_REQ;
  assign gnt_clr   = ~gnt_rd & (state_q == C_RUN);
  assign gnt_fifo  = ~gnt_rd & ~gnt_clr & ~empty;
  assign {head_addr, head_data} = fifo_q[rptr_q];

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_data_d  = clr_data_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rd_p_d      = bus.iRD_REQ;
    rd_vld_d    = rd_p_q;
    ovf_d       = ovf_q | (bus.iWR_EN & full);

    if (push)     wptr_d = wptr_q + PTR_W'(1);
    if (gnt_fifo) rptr_d = rptr_q + PTR_W'(1);
    if (push && !gnt_fifo)      cnt_d = cnt_q + LVL_W'(1);
    else if (!push && gnt_fifo) cnt_d = cnt_q - LVL_W'(1);

    unique case (1'b1)
      gnt_rd: mem_addr_d = bus.iRD_ADDR;
      gnt_clr: begin
        mem_addr_d  = clr_addr_q;
        mem_wdata_d = clr_data_q;
        mem_we_d    = 1'b1;
      end
      gnt_fifo: begin
        mem_addr_d  = head_addr;
        mem_wdata_d = head_data;
        // out-of-range entries are drained but never written
        mem_we_d    = (head_addr <= LAST);
      end
      default: ;
    endcase

    unique case (state_q)
      C_IDLE: begin
        if (bus.iCLR_START && empty) begin
          state_d    = C_RUN;
          clr_addr_d = '0;
          clr_data_d = bus.iCLR_DATA;
        end
      end
      C_RUN: begin
        if (gnt_clr) begin
          if (clr_addr_q == LAST) state_d = C_IDLE;
          else clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= C_IDLE;
      clr_addr_q  <= '0;
      clr_data_q  <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rd_p_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_data_q  <= clr_data_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rd_p_q      <= rd_p_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (push) fifo_q[wptr_q] <= {bus.iWR_ADDR, bus.iWR_DATA};
  end

  assign bus.oWR_FULL    = full;
  assign bus.oFIFO_LEVEL = cnt_q;
  assign bus.oOVF        = ovf_q;
  assign bus.oRD_VALID   = rd_vld_q;
  assign bus.oRD_DATA    = rd_vld_q ? bus.iMEM_Q : '0;
  assign bus.oCLR_BUSY   = (state_q == C_RUN);
  assign bus.oMEM_ADDR   = mem_addr_q;
  assign bus.oMEM_WDATA  = mem_wdata_q;
  assign bus.oMEM_WE     = mem_we_q;

endmodule

// File: doc/vga_index_mem_arbiter.md
Name: vga_index_mem_arbiter

Overview:
- Shares the single-port VGA pixel-index RAM between three requesters: VGA refresh reads, processor pixel writes, and a full-screen clear engine.
- Processor writes are buffered in a small FIFO, so the processor never stalls on refresh traffic.
- Sits between the processor's memory-write outputs and the vga_controller index RAM, all on VGA_CTRL_CLK.

Parameters:
- ADDR_W, 19, pixel address width (640x480 = 307200 < 2^19).
- DATA_W, 8, colour-index width.
- FIFO_DEPTH, 16, write FIFO entries; power of two, at least 2.
- MEM_DEPTH, 307200, number of valid RAM locations.

Ports:
- iCLK  in  1  VGA control clock.
- iRST  in  1  asynchronous reset, active-high.
- iWR_EN  in  1  processor write strobe, one entry per cycle.
- iWR_ADDR  in  ADDR_W  processor write address.
- iWR_DATA  in  DATA_W  processor write index.
- oWR_FULL  out  1  FIFO full; writes are not accepted.
- oFIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- oOVF  out  1  sticky flag: a write was attempted while full.
- iRD_REQ  in  1  VGA refresh read request.
- iRD_ADDR  in  ADDR_W  refresh read address.
- oRD_DATA  out  DATA_W  read data (valid when oRD_VALID).
- oRD_VALID  out  1  read data valid.
- iCLR_START  in  1  clear request pulse.
- iCLR_DATA  in  DATA_W  fill index, sampled at start.
- oCLR_BUSY  out  1  clear in progress.
- oMEM_ADDR  out  ADDR_W  RAM address, registered.
- oMEM_WDATA  out  DATA_W  RAM write data, registered.
- oMEM_WE  out  1  RAM write enable, registered.
- iMEM_Q  in  DATA_W  RAM read data; synchronous RAM, valid the cycle after address.

Behaviour:
- Reset values: all outputs 0. FIFO empty, clear FSM in C_IDLE, oOVF=0, read pipeline cleared.
- Per-cycle grant, fixed priority:
  1. iRD_REQ: read.
  2. Clear FSM in C_RUN: clear write.
  3. FIFO non-empty: FIFO write.
  4. Otherwise idle: oMEM_WE=0, oMEM_ADDR holds its last value.
- Exactly one grant per cycle. The granted access appears on the oMEM_* registers after the same clock edge.
- Read path:
  - iRD_REQ sampled at edge k puts iRD_ADDR on oMEM_ADDR with oMEM_WE=0 after edge k.
  - oRD_VALID is high for the cycle after edge k+1; oRD_DATA = iMEM_Q in that cycle.
  - Latency is fixed at 2 cycles, fully pipelined, one read per cycle.
- FIFO push:
  - Occurs when iWR_EN && !oWR_FULL, with full judged on the pre-edge count.
  - A simultaneous pop does not permit a push into a full FIFO.
  - iWR_EN while full drops the entry and sets oOVF, which clears only on reset.
- FIFO pop:
  - Occurs only when the FIFO write is granted. The popped entry drives oMEM_ADDR, oMEM_WDATA and oMEM_WE=1.
  - An entry with address >= MEM_DEPTH is popped with oMEM_WE=0 (discarded).
- Simultaneous push and pop when non-full: count unchanged. oFIFO_LEVEL = count, updated after each edge. Read and write pointers wrap modulo FIFO_DEPTH.
- Clear FSM states are C_IDLE and C_RUN:
  - C_IDLE -> C_RUN on iCLR_START when the FIFO is empty. Start latches iCLR_DATA and sets clr_addr=0.
  - iCLR_START is ignored if the FIFO is non-empty or the FSM is already in C_RUN.
  - In C_RUN, each granted clear cycle writes clr_addr and increments it. Cycles stolen by reads do not advance it.
  - After writing MEM_DEPTH-1 the FSM returns to C_IDLE. oCLR_BUSY = (state == C_RUN), so it falls the cycle after the last write.
  - Processor writes arriving during a clear queue in the FIFO and drain after the clear, so post-start writes always land on top of the clear.
  - If the FIFO fills during a clear, oWR_FULL is asserted and writes are dropped per the overflow rule.
- Asynchronous reset mid-operation aborts any clear (RAM contents partial), empties the FIFO, and kills in-flight oRD_VALID.

Test Plan:
- Reset, then push 3 writes (addr 10, 11, 12; data 5, 6, 7) with iRD_REQ=0 -> oMEM_WE pulses on 3 consecutive cycles with matching addr/data; oFIFO_LEVEL returns to 0.
- iRD_REQ continuously high for 20 cycles while pushing 16 writes -> oMEM_WE stays 0; oWR_FULL=1 after 16 pushes; a 17th push sets oOVF=1; after iRD_REQ drops, all 16 entries drain in order.
- Read addr 100 with RAM preloaded to 0x3C -> oRD_VALID=1 exactly 2 cycles after the request, with oRD_DATA=0x3C. Back-to-back reads of addr 0..7 -> 8 consecutive valid cycles.
- iCLR_START with iCLR_DATA=0x0F and the FIFO empty -> oCLR_BUSY for MEM_DEPTH write cycles plus cycles stolen by reads; every RAM location = 0x0F. A write to addr 5 issued mid-clear reads back its own data afterwards.
- iCLR_START with FIFO level 2 -> ignored, oCLR_BUSY stays 0. A second iCLR_START during C_RUN -> clr_addr is not restarted.
- Assert iRST mid-clear at clr_addr ~1000 with the FIFO holding 4 entries -> immediately oCLR_BUSY=0, oFIFO_LEVEL=0, oMEM_WE=0, oRD_VALID=0.
